// File: rtl/noc_out_arb_02.sv
// Output-port arbiter for router 02: pops one of the S/W/L input FIFO heads and forwards the flit
// to the next hop. Packets hold the port head to tail; packets are served round-robin; pops are credit-gated.
module noc_out_arb_02 #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 3,
    parameter int DATASIZE = 40
) (
    input  logic                fifo_clk,
    input  logic                rst,
    input  logic [DATASIZE-1:0] S_data_in,
    input  logic [DATASIZE-1:0] W_data_in,
    input  logic [DATASIZE-1:0] L_data_in,
    input  logic                S_valid_in,
    input  logic                W_valid_in,
    input  logic                L_valid_in,
    output logic                fifo_ready_S,
    output logic                fifo_ready_W,
    output logic                fifo_ready_L,
    output logic [DATASIZE-1:0] out_data,
    output logic                out_valid,
    input  logic                down_full,
    input  logic [WIDTH:0]      down_pressure,
    output logic                busy
);

    typedef enum logic {IDLE, LOCK} state_t;
    typedef enum logic [1:0] {PORT_S = 2'd0, PORT_W = 2'd1, PORT_L = 2'd2} port_t;

    state_t              state;
    port_t               owner;
    port_t               rr;
    port_t               grant;
    port_t               candidate;
    logic                grant_valid;
    logic                pop;
    logic                credit_ok;
    logic [WIDTH+1:0]    credit_sum;
    logic [DATASIZE-1:0] grant_data;
    logic                grant_tail;

    function automatic port_t next_port(input port_t p);
        case (p)
            PORT_S:  return PORT_W;
            PORT_W:  return PORT_L;
            default: return PORT_S;
        endcase
    endfunction

    function automatic logic port_valid(input port_t p, input logic vs, input logic vw, input logic vl);
        case (p)
            PORT_S:  return vs;
            PORT_W:  return vw;
            PORT_L:  return vl;
            default: return 1'b0;
        endcase
    endfunction

    // The write already in flight is not yet visible in down_pressure, so it is counted here.
    always_comb begin
        credit_sum = {1'b0, down_pressure} + {{(WIDTH+1){1'b0}}, out_valid};
        credit_ok  = !down_full && (credit_sum < (WIDTH+2)'(DEPTH));
    end

    always_comb begin
        grant       = PORT_S;
        grant_valid = 1'b0;
        candidate   = rr;
        if (state == LOCK) begin
            grant       = owner;
            grant_valid = port_valid(owner, S_valid_in, W_valid_in, L_valid_in);
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!grant_valid && port_valid(candidate, S_valid_in, W_valid_in, L_valid_in)) begin
                    grant       = candidate;
                    grant_valid = 1'b1;
                end
                candidate = next_port(candidate);
            end
        end
    end

    always_comb begin
        case (grant)
            PORT_W:  grant_data = W_data_in;
            PORT_L:  grant_data = L_data_in;
            default: grant_data = S_data_in;
        endcase
        grant_tail   = grant_data[DATASIZE-1];
        pop          = grant_valid && credit_ok && !rst;
        fifo_ready_S = pop && (grant == PORT_S);
        fifo_ready_W = pop && (grant == PORT_W);
        fifo_ready_L = pop && (grant == PORT_L);
    end

    assign busy = (state == LOCK);

    // A head flit without tail locks the port to its input; the tail releases it and advances rr.
    always_ff @(posedge fifo_clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= PORT_S;
            rr        <= PORT_S;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= pop;
            if (pop) begin
                out_data <= grant_data;
                case (state)
                    IDLE: begin
                        if (!grant_tail) begin
                            state <= LOCK;
                            owner <= grant;
                        end else begin
                            rr <= next_port(grant);
                        end
                    end
                    LOCK: begin
                        if (grant_tail) begin
                            state <= IDLE;
                            rr    <= next_port(owner);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_noc_out_arb_02.sv
// Randomized and directed bench for noc_out_arb_02; upstream FIFOs are queues and a
// packet-level reference model predicts pops, forwarded flits and the lock flag.
module tb_noc_out_arb_02;

    localparam int DEPTH = 8;
    localparam int WIDTH = 3;
    localparam int DS    = 40;

    logic          fifo_clk = 1'b0;
    logic          rst;
    logic [DS-1:0] S_data_in, W_data_in, L_data_in;
    logic          S_valid_in, W_valid_in, L_valid_in;
    logic          fifo_ready_S, fifo_ready_W, fifo_ready_L;
    logic [DS-1:0] out_data;
    logic          out_valid;
    logic          down_full;
    logic [WIDTH:0] down_pressure;
    logic          busy;

    noc_out_arb_02 #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DS)) dut (
        .fifo_clk(fifo_clk), .rst(rst),
        .S_data_in(S_data_in), .W_data_in(W_data_in), .L_data_in(L_data_in),
        .S_valid_in(S_valid_in), .W_valid_in(W_valid_in), .L_valid_in(L_valid_in),
        .fifo_ready_S(fifo_ready_S), .fifo_ready_W(fifo_ready_W), .fifo_ready_L(fifo_ready_L),
        .out_data(out_data), .out_valid(out_valid),
        .down_full(down_full), .down_pressure(down_pressure), .busy(busy)
    );

    always #5 fifo_clk = ~fifo_clk;

    logic [DS-1:0] q_s[$];
    logic [DS-1:0] q_w[$];
    logic [DS-1:0] q_l[$];
    logic [2:0]    gate;
    int            seq;
    int            errors;
    int            checks;
    int            pop_log[$];

    // Reference model: who holds the port (-1 = nobody), whose turn it is, and what is in flight.
    int            rr_m;
    int            owner_m;
    logic          exp_ov;
    logic [DS-1:0] exp_od;

    function automatic int q_size(input int i);
        case (i)
            0:       return q_s.size();
            1:       return q_w.size();
            default: return q_l.size();
        endcase
    endfunction

    function automatic logic [DS-1:0] q_head(input int i);
        if (q_size(i) == 0) return '0;
        case (i)
            0:       return q_s[0];
            1:       return q_w[0];
            default: return q_l[0];
        endcase
    endfunction

    task automatic q_pop(input int i);
        case (i)
            0:       void'(q_s.pop_front());
            1:       void'(q_w.pop_front());
            default: void'(q_l.pop_front());
        endcase
    endtask

    task automatic load_packet(input int i, input int len);
        logic [DS-1:0] flit;
        for (int f = 0; f < len; f++) begin
            flit = {(f == len - 1), 7'(i), 32'(seq)};
            seq++;
            case (i)
                0:       q_s.push_back(flit);
                1:       q_w.push_back(flit);
                default: q_l.push_back(flit);
            endcase
        end
    endtask

    task automatic clear_queues();
        q_s.delete();
        q_w.delete();
        q_l.delete();
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock per iteration: drive heads, predict and check at negedge, then advance the model.
    task automatic applyStimulus(input int n);
        logic [2:0]    v;
        logic          credit;
        logic          pop;
        logic [DS-1:0] flit;
        int            g;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 3; i++) v[i] = gate[i] && (q_size(i) > 0);
            S_valid_in = v[0]; S_data_in = q_head(0);
            W_valid_in = v[1]; W_data_in = q_head(1);
            L_valid_in = v[2]; L_data_in = q_head(2);
            @(negedge fifo_clk);
            credit = !down_full && ((int'(down_pressure) + int'(exp_ov)) < DEPTH);
            g = -1;
            if (owner_m >= 0) begin
                if (v[owner_m]) g = owner_m;
            end else begin
                for (int k = 0; k < 3; k++)
                    if (g < 0 && v[(rr_m + k) % 3]) g = (rr_m + k) % 3;
            end
            pop = (g >= 0) && credit && !rst;
            checkOutput("ready_S", 64'(fifo_ready_S), 64'(pop && g == 0));
            checkOutput("ready_W", 64'(fifo_ready_W), 64'(pop && g == 1));
            checkOutput("ready_L", 64'(fifo_ready_L), 64'(pop && g == 2));
            checkOutput("out_valid", 64'(out_valid), 64'(exp_ov));
            checkOutput("out_data", 64'(out_data), 64'(exp_od));
            checkOutput("busy", 64'(busy), 64'(owner_m >= 0));
            if (fifo_ready_S) pop_log.push_back(0);
            if (fifo_ready_W) pop_log.push_back(1);
            if (fifo_ready_L) pop_log.push_back(2);
            @(posedge fifo_clk);
            if (rst) begin
                exp_ov  = 1'b0;
                exp_od  = '0;
                owner_m = -1;
                rr_m    = 0;
            end else begin
                exp_ov = pop;
                if (pop) begin
                    flit   = q_head(g);
                    exp_od = flit;
                    q_pop(g);
                    if (flit[DS-1]) begin
                        owner_m = -1;
                        rr_m    = (g + 1) % 3;
                    end else begin
                        owner_m = g;
                    end
                end
            end
            #1;
        end
    endtask

    task automatic check_log(input string tag, input int n, input int e0, input int e1, input int e2,
                             input int e3, input int e4, input int e5);
        int e[6];
        e = '{e0, e1, e2, e3, e4, e5};
        checkOutput({tag, "_count"}, 64'(pop_log.size()), 64'(n));
        for (int i = 0; i < n && i < pop_log.size(); i++)
            checkOutput(tag, 64'(pop_log[i]), 64'(e[i]));
    endtask

    initial begin
        errors = 0; checks = 0; seq = 1;
        rr_m = 0; owner_m = -1; exp_ov = 1'b0; exp_od = '0;
        rst = 1'b1; down_full = 1'b0; down_pressure = '0; gate = 3'b111;

        // Reset held with every input valid: nothing may be popped.
        load_packet(0, 1); load_packet(1, 1); load_packet(2, 1);
        applyStimulus(3);
        clear_queues();
        rst = 1'b0;

        // Round-robin across single-flit packets.
        load_packet(0, 1); load_packet(1, 1); load_packet(2, 1);
        load_packet(0, 1); load_packet(1, 1); load_packet(2, 1);
        pop_log.delete();
        applyStimulus(8);
        check_log("rr_order", 6, 0, 1, 2, 0, 1, 2);

        // Wormhole: S's 3-flit packet goes out whole before W.
        load_packet(0, 3); load_packet(1, 1);
        pop_log.delete();
        applyStimulus(6);
        check_log("worm_order", 4, 0, 0, 0, 1, 0, 0);

        // Credit boundary at pressure DEPTH-1, then down_full blocks everything.
        down_pressure = 4'(DEPTH - 1);
        for (int i = 0; i < 4; i++) load_packet(2, 1);
        pop_log.delete();
        applyStimulus(2);
        checkOutput("credit_one_pop", 64'(pop_log.size()), 64'd1);
        down_full = 1'b1; down_pressure = '0;
        pop_log.delete();
        applyStimulus(4);
        checkOutput("full_no_pop", 64'(pop_log.size()), 64'd0);
        down_full = 1'b0;
        applyStimulus(5);

        // Locked owner runs dry: W must wait even though it is valid.
        load_packet(0, 2); load_packet(1, 1);
        pop_log.delete();
        applyStimulus(1);
        check_log("stall_head", 1, 0, 0, 0, 0, 0, 0);
        gate[0] = 1'b0;
        pop_log.delete();
        applyStimulus(4);
        checkOutput("stall_no_pop", 64'(pop_log.size()), 64'd0);
        gate[0] = 1'b1;
        pop_log.delete();
        applyStimulus(1);
        check_log("stall_resume", 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(3);

        // Reset in the middle of a W packet drops the lock and returns the turn to S.
        load_packet(1, 3);
        applyStimulus(2);
        rst = 1'b1;
        applyStimulus(1);
        clear_queues();
        rst = 1'b0;
        load_packet(0, 1); load_packet(1, 1);
        pop_log.delete();
        applyStimulus(4);
        check_log("post_reset", 2, 0, 1, 0, 0, 0, 0);

        // Random traffic, gaps, back-pressure and occasional reset.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 3; i++)
                if (q_size(i) < 6 && $urandom_range(0, 3) == 0) load_packet(i, $urandom_range(1, 4));
            gate          = {($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0)};
            down_pressure = 4'($urandom_range(0, DEPTH));
            down_full     = ($urandom_range(0, 9) == 0);
            rst           = ($urandom_range(0, 99) == 0);
            applyStimulus(1);
            if (rst) clear_queues();
            rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/noc_out_arb_02.md
# noc_out_arb_02

Output-port arbiter for router 02: the read side of the S/W/L input-FIFO bundle. It selects one of the three input FIFO heads, pops it with a one-cycle `fifo_ready_*` strobe, and forwards the flit one cycle later into the next hop's input FIFO as a one-cycle write pulse. Wormhole switching: a grant is held from head flit to tail flit. Round-robin across packets. Credit-gated against the downstream FIFO's occupancy so that FIFO never overflows.

## Interface
- `DEPTH`, 8, depth of the downstream FIFO (credit limit).
- `WIDTH`, 3, log2(DEPTH); pressure ports are WIDTH+1 bits.
- `DATASIZE`, 40, flit width; bit DATASIZE-1 is the tail flag (1 = last flit of packet).

Ports:
- `fifo_clk` in 1 — single clock, all state on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `S_data_in`, `W_data_in`, `L_data_in` in DATASIZE — input FIFO head words, valid in the same cycle as their valid (first-word fall-through).
- `S_valid_in`, `W_valid_in`, `L_valid_in` in 1 — input FIFO non-empty.
- `fifo_ready_S`, `fifo_ready_W`, `fifo_ready_L` out 1 — pop strobes; at most one high per cycle.
- `out_data` out DATASIZE — forwarded flit, registered.
- `out_valid` out 1 — one-cycle write pulse to the downstream FIFO.
- `down_full` in 1 — downstream FIFO full.
- `down_pressure` in WIDTH+1 — downstream FIFO occupancy count.
- `busy` out 1 — high while a multi-flit packet holds the grant (LOCK).

## Operation
- State: `state` ∈ {IDLE, LOCK}; `owner` ∈ {S, W, L}; round-robin pointer `rr` ∈ {S, W, L}, with order S→W→L→S.
- Credit: `credit_ok = !down_full && (down_pressure + out_valid) < DEPTH`, computed at WIDTH+2 bits. `out_valid` counts the write already in flight, which is not yet reflected in `down_pressure`.
- In IDLE, `grant` = the first valid input found searching from `rr` in rotating order. If no input is valid, there is no grant.
- In LOCK, `grant` = `owner` only, and only if that input is valid. Other inputs are ignored.
- Pop condition: grant exists && `credit_ok` && !`rst`. On pop, `fifo_ready_<grant>` is high for that cycle, combinationally. All other `fifo_ready_*` are low.
- On pop, the flit is registered to `out_data`, and `out_valid` is 1 in the next cycle. With no pop, `out_valid` is 0 and `out_data` holds its last value.
- Transitions on pop:
  - IDLE with a non-tail flit → LOCK, `owner`=grant.
  - IDLE with a tail flit (single-flit packet) → stay IDLE, `rr`=grant+1.
  - LOCK with a tail flit → IDLE, `rr`=owner+1.
  - LOCK with a non-tail flit → stay in LOCK.
- No pop → no state change. A LOCK owner that runs empty mid-packet stalls the port; there is no timeout.
- `busy` = (state == LOCK).

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `busy`=0, state=IDLE, `rr`=S, `owner`=S. All `fifo_ready_*` are 0 while `rst`=1.
- Latency: pop in cycle t → `out_valid`/`out_data` in cycle t+1.
- Throughput: 1 flit/cycle while credit allows.
- Credit boundary: `down_pressure`=DEPTH-1 with `out_valid`=1 → no pop. `down_pressure`=DEPTH-1 with `out_valid`=0 → pop allowed.
- `down_full`=1 blocks popping regardless of pressure.
- Simultaneous valids in IDLE: the rotating search from `rr` decides the grant. There are no ties.
- Tail and head flits from different inputs can go out back-to-back. After a tail in cycle t, a new grant is possible in cycle t+1.
- Reset mid-packet:
  - The lock is dropped and `rr` returns to S.
  - An `out_valid` due in the cycle after reset asserts is suppressed.
  - The upstream FIFOs share the reset, so no partial packet survives.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with all valids=1 → all `fifo_ready_*`=0, `out_valid`=0, `out_data`=0, `busy`=0.
- Round-robin: S, W and L each hold 2 single-flit packets (tail=1), `down_pressure`=0 → pop order S,W,L,S,W,L, one per cycle; each `out_valid` pulse comes 1 cycle after its pop.
- Wormhole lock: S holds a 3-flit packet (tail only on flit 3) and W holds 1 flit, both valid at once → S flits 1-3 go out consecutively, `busy`=1 for 2 cycles, then W is popped on the cycle after S's tail.
- Credit: `DEPTH`=8, `down_pressure` held at 7, L has 4 flits → exactly one pop, then none while `out_valid`=1 and pressure stays 7; no pops at all when `down_full`=1.
- Owner stall: S is in LOCK after flit 1, S goes empty for 4 cycles while W is valid → no pops; S's flit 2 is popped as soon as S becomes valid again.
- Mid-packet reset: `rst` asserted during LOCK on W → the next cycle has `out_valid`=0 and `busy`=0; after release with S and W valid, S is granted first.
